// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the sequential ALU.
package seq_alu_pkg;

  localparam int unsigned OPW   = 4;
  localparam int unsigned FLAGW = 5;

  localparam logic [OPW-1:0] OP_ADD  = 4'd0;
  localparam logic [OPW-1:0] OP_SUB  = 4'd1;
  localparam logic [OPW-1:0] OP_MUL  = 4'd2;
  localparam logic [OPW-1:0] OP_DIV  = 4'd3;
  localparam logic [OPW-1:0] OP_ROL  = 4'd4;
  localparam logic [OPW-1:0] OP_ROR  = 4'd5;
  localparam logic [OPW-1:0] OP_PENC = 4'd6;
  localparam logic [OPW-1:0] OP_GRAY = 4'd7;
  localparam logic [OPW-1:0] OP_REM  = 4'd8;
  localparam logic [OPW-1:0] OP_RSVD = 4'd9;
  localparam logic [OPW-1:0] OP_AND  = 4'd10;
  localparam logic [OPW-1:0] OP_OR   = 4'd11;
  localparam logic [OPW-1:0] OP_NOT  = 4'd12;
  localparam logic [OPW-1:0] OP_XOR  = 4'd13;
  localparam logic [OPW-1:0] OP_GT   = 4'd14;
  localparam logic [OPW-1:0] OP_EQ   = 4'd15;

  localparam int unsigned FLG_ZERO  = 4;
  localparam int unsigned FLG_CARRY = 3;
  localparam int unsigned FLG_SIGN  = 2;
  localparam int unsigned FLG_OVF   = 1;
  localparam int unsigned FLG_ERR   = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // True for the opcodes served by the iterative divider.
  function automatic logic is_div_op(input logic [OPW-1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/seq_alu_divider.sv
// Restoring unsigned divider; the first quotient bit is resolved on the start
// edge so WIDTH iterations complete in WIDTH cycles, done pulses one cycle after.
module seq_alu_divider
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CNTW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_src_rem;
  logic [WIDTH-1:0] w_src_quo;
  logic [WIDTH-1:0] w_src_div;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_nxt_rem;
  logic [WIDTH-1:0] w_nxt_quo;

  // One restoring step, fed from the fresh operands on start, else from state.
  always_comb begin
    w_src_rem = i_start ? '0         : r_rem;
    w_src_quo = i_start ? i_dividend : r_quo;
    w_src_div = i_start ? i_divisor  : r_div;
    w_trial   = {w_src_rem, w_src_quo[WIDTH-1]};
    w_ge      = (w_trial >= {1'b0, w_src_div});
    w_nxt_rem = w_ge ? WIDTH'(w_trial - {1'b0, w_src_div}) : w_trial[WIDTH-1:0];
    w_nxt_quo = {w_src_quo[WIDTH-2:0], w_ge};
  end

  // Iteration state; a reset abandons any divide in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_nxt_rem;
        r_quo  <= w_nxt_quo;
        r_div  <= i_divisor;
        r_cnt  <= CNTW'(WIDTH - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_nxt_rem;
        r_quo <= w_nxt_quo;
        r_cnt <= r_cnt - CNTW'(1);
        if (r_cnt == CNTW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/seq_alu_core.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and an iterative divider.
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam int unsigned IDXW = $clog2(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_flags;
  logic             r_op_rem;

  logic             w_accept;
  logic             w_div_start;
  logic             w_load_alu;
  logic             w_load_div;
  logic             w_clear_out;

  logic             w_div_busy;
  logic             w_div_done;
  logic [WIDTH-1:0] w_div_quo;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_result;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [PW-1:0]    w_prod;
  logic [IDXW-1:0]  w_penc_idx;
  logic [WIDTH-1:0] w_alu_result;
  logic [4:0]       w_alu_flags;

  // Accept only when idle, or when the held result is drained this same cycle.
  assign in_ready = !rst && !w_div_busy &&
                    ((r_state == IDLE) || ((r_state == HOLD) && out_ready));

  seq_alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_div_start),
    .i_dividend  (a),
    .i_divisor   (b),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_div_quo),
    .o_remainder (w_div_rem)
  );

  // Highest set bit of a; all ones when a is zero.
  always_comb begin
    w_penc_idx = '1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (a[i]) w_penc_idx = IDXW'(i);
    end
  end

  // Single-cycle operations, evaluated on the operands being accepted.
  always_comb begin
    w_sum        = {1'b0, a} + {1'b0, b};
    w_diff       = {1'b0, a} - {1'b0, b};
    w_prod       = PW'(a) * PW'(b);
    w_alu_result = '0;
    w_alu_flags  = '0;
    case (opcode)
      OP_ADD: begin
        w_alu_result           = w_sum[WIDTH-1:0];
        w_alu_flags[FLG_CARRY] = w_sum[WIDTH];
        w_alu_flags[FLG_OVF]   = (a[WIDTH-1] == b[WIDTH-1]) &&
                                 (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_result           = w_diff[WIDTH-1:0];
        w_alu_flags[FLG_CARRY] = w_diff[WIDTH];
        w_alu_flags[FLG_OVF]   = (a[WIDTH-1] != b[WIDTH-1]) &&
                                 (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: begin
        w_alu_result           = w_prod[WIDTH-1:0];
        w_alu_flags[FLG_CARRY] = (w_prod[PW-1:WIDTH] != '0);
      end
      OP_DIV, OP_REM: w_alu_flags[FLG_ERR] = (b == '0);
      OP_ROL:  w_alu_result = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  w_alu_result = {a[0], a[WIDTH-1:1]};
      OP_PENC: w_alu_result = WIDTH'(w_penc_idx);
      OP_GRAY: w_alu_result = a ^ (a >> 1);
      OP_AND:  w_alu_result = a & b;
      OP_OR:   w_alu_result = a | b;
      OP_NOT:  w_alu_result = ~a;
      OP_XOR:  w_alu_result = a ^ b;
      OP_GT:   w_alu_result = WIDTH'(a > b);
      OP_EQ:   w_alu_result = WIDTH'(a == b);
      default: w_alu_flags[FLG_ERR] = 1'b1;
    endcase
    w_alu_flags[FLG_ZERO] = (w_alu_result == '0);
    w_alu_flags[FLG_SIGN] = w_alu_result[WIDTH-1];
  end

  assign w_div_result = r_op_rem ? w_div_rem : w_div_quo;

  // Next state and datapath load strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = in_valid && in_ready;
    w_div_start = 1'b0;
    w_load_alu  = 1'b0;
    w_load_div  = 1'b0;
    w_clear_out = 1'b0;
    case (r_state)
      IDLE, HOLD: begin
        if (w_accept) begin
          if (is_div_op(opcode) && (b != '0)) begin
            w_div_start = 1'b1;
            w_state_nxt = DIVIDE;
          end else begin
            w_load_alu  = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if ((r_state == HOLD) && out_ready) begin
          w_clear_out = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DIVIDE: begin
        if (w_div_done) begin
          w_load_div  = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Result, flags and output valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_op_rem    <= 1'b0;
    end else begin
      if (w_load_alu) begin
        r_result    <= w_alu_result;
        r_flags     <= w_alu_flags;
        r_out_valid <= 1'b1;
      end else if (w_load_div) begin
        r_result    <= w_div_result;
        r_flags     <= {(w_div_result == '0), 1'b0, w_div_result[WIDTH-1], 2'b00};
        r_out_valid <= 1'b1;
      end else if (w_div_start || w_clear_out) begin
        r_out_valid <= 1'b0;
      end
      if (w_div_start) r_op_rem <= (opcode == OP_REM);
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_seq_alu_core.sv
// Directed self-checking bench for seq_alu_core at WIDTH=8.
module tb_seq_alu_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [4:0] flags;

  int n_cmp = 0;
  int n_err = 0;

  seq_alu_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, measure latency, check outputs, then drain it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] va,
                        input logic [7:0] vb, input int exp_lat,
                        input logic [7:0] exp_res, input logic [4:0] exp_flg);
    int   n;
    logic rdy_seen;
    opcode   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    tick();
    // Keep presenting junk: it must be ignored and must not disturb the op.
    a      = 8'($urandom);
    b      = 8'($urandom);
    opcode = 4'd0;
    n        = 1;
    rdy_seen = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_res"}, 32'(result), 32'(exp_res));
    check({tag, "_flg"}, 32'(flags), 32'(exp_flg));
    if (exp_lat > 1) check({tag, "_rdy_busy"}, 32'(rdy_seen), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int   vcount;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = '0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_flags",     32'(flags),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    //      tag       op     a      b      lat res    flags {z,c,s,v,e}
    run_op("add",    4'd0,  8'd200, 8'd100, 1, 8'h2C, 5'b01000);
    run_op("sub",    4'd1,  8'd5,   8'd7,   1, 8'hFE, 5'b01100);
    run_op("addovf", 4'd0,  8'h7F,  8'h01,  1, 8'h80, 5'b00110);
    run_op("div",    4'd3,  8'd200, 8'd7,   9, 8'd28, 5'b00000);
    run_op("rem",    4'd8,  8'd200, 8'd7,   9, 8'd4,  5'b00000);
    run_op("div0",   4'd3,  8'd55,  8'd0,   1, 8'd0,  5'b10001);
    run_op("rsvd",   4'd9,  8'h12,  8'h34,  1, 8'd0,  5'b10001);
    run_op("penc0",  4'd6,  8'h00,  8'h00,  1, 8'h07, 5'b00000);
    run_op("penc28", 4'd6,  8'h28,  8'h00,  1, 8'h05, 5'b00000);
    run_op("gray",   4'd7,  8'hB4,  8'h00,  1, 8'hEE, 5'b00100);
    run_op("not",    4'd12, 8'h0F,  8'h00,  1, 8'hF0, 5'b00100);
    run_op("xor",    4'd13, 8'h5A,  8'h5A,  1, 8'h00, 5'b10000);
    run_op("gt_lo",  4'd14, 8'd3,   8'd9,   1, 8'h00, 5'b10000);
    run_op("gt_hi",  4'd14, 8'd9,   8'd3,   1, 8'h01, 5'b00000);
    run_op("rol",    4'd4,  8'h81,  8'h00,  1, 8'h03, 5'b00000);
    run_op("ror",    4'd5,  8'h01,  8'h00,  1, 8'h80, 5'b00100);

    // Backpressure: MUL held for 5 cycles while an EQ waits on the input.
    opcode   = 4'd2;
    a        = 8'd16;
    b        = 8'd17;
    in_valid = 1'b1;
    tick();
    opcode = 4'd15;
    a      = 8'd3;
    b      = 8'd3;
    check("mul_valid", 32'(out_valid), 32'd1);
    check("mul_flg",   32'(flags),     32'(5'b01000));
    for (int i = 0; i < 5; i++) begin
      check("mul_hold_res", 32'(result),   32'h10);
      check("mul_hold_rdy", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("eq_valid", 32'(out_valid), 32'd1);
    check("eq_res",   32'(result),    32'd1);
    check("eq_flg",   32'(flags),     32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("eq_drain", 32'(out_valid), 32'd0);

    // Reset during the 4th DIVIDE cycle abandons the divide.
    opcode   = 4'd3;
    a        = 8'd200;
    b        = 8'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rstdiv_rdy_in_rst", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rstdiv_in_ready", 32'(in_ready),  32'd1);
    check("rstdiv_valid",    32'(out_valid), 32'd0);
    check("rstdiv_result",   32'(result),    32'd0);
    check("rstdiv_flags",    32'(flags),     32'd0);
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) vcount++;
      tick();
    end
    check("rstdiv_no_result", 32'(vcount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
